lcd_arbiter: RTL

- Sequencer and arbiter in front of the L1602A LCD controller.
- Issues the power-up INIT command automatically after reset.
- Shares the controller between two requesters using round-robin arbitration, with packet lock for multi-character strings.
- Drives the controller's op/data/enable inputs and tracks its ready output to know when each command completes.

---
 rtl/lcd_pkg.sv | 27 ++
 rtl/lcd_rr_arb.sv | 24 ++
 rtl/lcd_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared op encoding, FSM state type and default timing constants for the L1602A LCD arbiter.
package lcd_pkg;

  localparam int unsigned OPW         = 6;
  localparam int unsigned OP_INIT     = 0;
  localparam int unsigned OP_WRITE    = 1;
  localparam int unsigned OP_CLEAR    = 2;
  localparam int unsigned DEF_ACC_MAX = 8;
  localparam int unsigned DEF_TIMEOUT = 400000;
  localparam int unsigned RETRY_MAX   = 2;

  typedef enum logic [2:0] {
    BOOT,
    IDLE,
    ISSUE,
    WAIT_ACC,
    WAIT_DONE
  } state_t;

  // True only for exactly one of the three defined op bits.
  function automatic logic op_legal(input logic [OPW-1:0] op);
    return (op == OPW'(1 << OP_INIT))  ||
           (op == OPW'(1 << OP_WRITE)) ||
           (op == OPW'(1 << OP_CLEAR));
  endfunction

endpackage

// File: rtl/lcd_rr_arb.sv
// Two-way round-robin arbiter; a held lock restricts the grant to the lock owner.
module lcd_rr_arb (
  input  logic [1:0] i_req,
  input  logic       i_lock,
  input  logic       i_lock_owner,
  input  logic       i_rr,
  output logic [1:0] o_win_c,
  output logic       o_valid_c
);

  always_comb begin
    o_win_c = '0;
    if (i_lock) begin
      if (i_req[i_lock_owner]) o_win_c[i_lock_owner] = 1'b1;
    end else if (i_req[i_rr]) begin
      o_win_c[i_rr] = 1'b1;
    end else if (i_req[~i_rr]) begin
      o_win_c[~i_rr] = 1'b1;
    end
  end

  assign o_valid_c = |o_win_c;

endmodule

// File: rtl/lcd_arbiter.sv
// Boot sequencer and two-requester arbiter in front of the L1602A LCD controller.
// Optional WAIT_DONE watchdog enabled by defining LCD_ARB_TIMEOUT_EN.
module lcd_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned ACC_MAX = DEF_ACC_MAX
`ifdef LCD_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
`endif
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [NREQ-1:0] i_req,
  input  logic [NREQ-1:0] i_req_last,
  input  logic [OPW-1:0]  i_req_op0,
  input  logic [OPW-1:0]  i_req_op1,
  input  logic [7:0]      i_req_data0,
  input  logic [7:0]      i_req_data1,
  output logic [NREQ-1:0] o_ack,
  output logic [NREQ-1:0] o_gnt,
  output logic [OPW-1:0]  o_lcd_op,
  output logic [7:0]      o_lcd_data,
  output logic            o_lcd_en,
  input  logic            i_lcd_rdy,
  output logic            o_busy,
  output logic            o_err
);

  localparam int unsigned ACCW = $clog2(ACC_MAX + 1);

  state_t          r_state;
  logic [OPW-1:0]  r_op;
  logic [7:0]      r_data;
  logic            r_en;
  logic [NREQ-1:0] r_ack;
  logic [NREQ-1:0] r_gnt;
  logic            r_busy;
  logic            r_owner;
  logic            r_self;
  logic            r_rr;
  logic            r_lock;
  logic [ACCW-1:0] r_acc_cnt;
  logic [1:0]      r_retry;

`ifdef LCD_ARB_TIMEOUT_EN
  localparam int unsigned TOW = $clog2(TIMEOUT + 1);
  logic [TOW-1:0]  r_to_cnt;
  logic            r_err;
`endif

  logic [1:0]      w_req_eff;
  logic [1:0]      w_win;
  logic            w_valid;
  logic            w_idx;
  logic [OPW-1:0]  w_op;
  logic [7:0]      w_data;
  logic            w_last;
  logic            w_acc_exp;
  logic            w_done;

  // A requester still shows its finished command during its ack cycle; hide it then.
  assign w_req_eff = i_req & ~r_ack;

  lcd_rr_arb u_arb (
    .i_req        (w_req_eff),
    .i_lock       (r_lock),
    .i_lock_owner (r_owner),
    .i_rr         (r_rr),
    .o_win_c      (w_win),
    .o_valid_c    (w_valid)
  );

  assign w_idx     = w_win[1];
  assign w_op      = w_idx ? i_req_op1 : i_req_op0;
  assign w_data    = w_idx ? i_req_data1 : i_req_data0;
  assign w_last    = i_req_last[w_idx];
  assign w_acc_exp = (r_acc_cnt == ACCW'(ACC_MAX - 1));

  // Completion: controller ready again, or the final acceptance retry ran out.
  assign w_done = ((r_state == WAIT_DONE) && i_lcd_rdy) ||
                  ((r_state == WAIT_ACC) && i_lcd_rdy && w_acc_exp &&
                   (r_retry == 2'(RETRY_MAX)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= BOOT;
      r_op      <= '0;
      r_data    <= '0;
      r_en      <= 1'b0;
      r_ack     <= '0;
      r_gnt     <= '0;
      r_busy    <= 1'b0;
      r_owner   <= 1'b0;
      r_self    <= 1'b0;
      r_rr      <= 1'b0;
      r_lock    <= 1'b0;
      r_acc_cnt <= '0;
      r_retry   <= '0;
`ifdef LCD_ARB_TIMEOUT_EN
      r_to_cnt  <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      r_ack <= '0;
      r_en  <= 1'b0;
      if (w_done) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_self  <= 1'b0;
        if (!r_self) begin
          r_ack[r_owner] <= 1'b1;
          r_rr           <= ~r_owner;
          r_lock         <= ~i_req_last[r_owner];
          if (i_req_last[r_owner]) r_gnt <= '0;
        end
      end else begin
        case (r_state)
          BOOT: begin
            r_busy <= 1'b1;
            r_gnt  <= '0;
            if (i_lcd_rdy) begin
              r_op    <= OPW'(1 << OP_INIT);
              r_data  <= '0;
              r_self  <= 1'b1;
              r_retry <= '0;
              r_en    <= 1'b1;
              r_state <= ISSUE;
            end
          end
          IDLE: begin
            if (w_valid) begin
              if (!op_legal(w_op)) begin
                // Illegal ops complete on the spot without touching the controller.
                r_ack   <= w_win;
                r_owner <= w_idx;
                r_rr    <= ~w_idx;
                r_lock  <= ~w_last;
                r_gnt   <= w_last ? '0 : w_win;
              end else if (i_lcd_rdy) begin
                r_op    <= w_op;
                r_data  <= w_data;
                r_gnt   <= w_win;
                r_owner <= w_idx;
                r_self  <= 1'b0;
                r_retry <= '0;
                r_en    <= 1'b1;
                r_busy  <= 1'b1;
                r_state <= ISSUE;
              end
            end
          end
          ISSUE: begin
            r_acc_cnt <= '0;
            r_state   <= WAIT_ACC;
          end
          WAIT_ACC: begin
            if (!i_lcd_rdy) begin
              r_state  <= WAIT_DONE;
`ifdef LCD_ARB_TIMEOUT_EN
              r_to_cnt <= '0;
`endif
            end else if (w_acc_exp) begin
              r_retry <= r_retry + 2'd1;
              r_en    <= 1'b1;
              r_state <= ISSUE;
            end else begin
              r_acc_cnt <= r_acc_cnt + ACCW'(1);
            end
          end
          WAIT_DONE: begin
`ifdef LCD_ARB_TIMEOUT_EN
            if (r_to_cnt == TOW'(TIMEOUT - 1)) begin
              r_err   <= 1'b1;
              if (!r_self) r_ack[r_owner] <= 1'b1;
              r_lock  <= 1'b0;
              r_gnt   <= '0;
              r_self  <= 1'b0;
              r_state <= BOOT;
            end else begin
              r_to_cnt <= r_to_cnt + TOW'(1);
            end
`endif
          end
          default: r_state <= BOOT;
        endcase
      end
    end
  end

  assign o_ack      = r_ack;
  assign o_gnt      = r_gnt;
  assign o_lcd_op   = r_op;
  assign o_lcd_data = r_data;
  assign o_lcd_en   = r_en;
  assign o_busy     = r_busy;
`ifdef LCD_ARB_TIMEOUT_EN
  assign o_err      = r_err;
`else
  assign o_err      = 1'b0;
`endif

endmodule
